// File: rtl/counter_sched.sv
// -----------------------------------------------------------------------------
// counter_sched
//   Round-robin scheduler that time-shares one external W-bit down-counter
//   among NREQ requesters. The served requester's value is loaded into the
//   counter, and the counter is decremented until it reports zero. A one-cycle
//   done pulse then goes back to that requester.
//
//   Optional feature (compile-time macro): COUNTER_SCHED_PRESCALE_EN
//     defined   : one decrement every PRESCALE cycles while counting down.
//     undefined : one decrement per cycle; PRESCALE is not used.
//
// Ports
//   clock      in   1       system clock, rising edge
//   reset_n    in   1       asynchronous active-low reset
//   req        in   NREQ    level requests, held until the matching done pulse
//   req_val    in   NREQ*W  countdown values, requester i at [i*W +: W]
//   grant      out  NREQ    one-hot; marks the served requester from LOAD to DONE
//   done       out  NREQ    one-cycle completion pulse
//   busy       out  1       high whenever the scheduler is not idle
//   cnt_in     out  W       load value for the counter
//   cnt_latch  out  1       counter load strobe
//   cnt_dec    out  1       counter decrement strobe (combinational)
//   cnt_zero   in   1       counter zero flag
// -----------------------------------------------------------------------------
module counter_sched #(
  parameter int NREQ     = 4,
  parameter int W        = 32,
  parameter int PRESCALE = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_val,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      cnt_in,
  output logic              cnt_latch,
  output logic              cnt_dec,
  input  logic              cnt_zero
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Elaboration-time parameter checks.
  generate
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("counter_sched: NREQ must be in 2..8");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("counter_sched: PRESCALE must be at least 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]      state_q,     state_d;
  logic [IW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [IW-1:0]   idx_q,       idx_d;
  logic [W-1:0]    val_q,       val_d;
  logic [NREQ-1:0] grant_q,     grant_d;
  logic [NREQ-1:0] done_q,      done_d;
  logic            busy_q,      busy_d;
  logic [W-1:0]    cnt_in_q,    cnt_in_d;
  logic            cnt_latch_q, cnt_latch_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: candidate gi is the requester gi positions after rr_ptr
  // (wrapping), so the lowest-offset active candidate is the winner.
  // ---------------------------------------------------------------------------
  logic [W-1:0]    req_slice [NREQ];
  logic [IW-1:0]   cand_idx  [NREQ];
  logic [NREQ-1:0] cand_req;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign req_slice[gi] = req_val[gi*W +: W];
      assign sum           = {1'b0, rr_ptr_q} + (IW+1)'(gi);
      assign cand_idx[gi]  = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ))
                                                     : sum[IW-1:0];
      assign cand_req[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  logic          pick_found;
  logic [IW-1:0] pick_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    // Walk from the farthest candidate down so the nearest one is kept.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  // Pointer for the next arbitration round: one past the served requester.
  logic [IW:0]   idx_inc;
  logic [IW-1:0] next_ptr;

  assign idx_inc  = {1'b0, idx_q} + (IW+1)'(1);
  assign next_ptr = (idx_inc == (IW+1)'(NREQ)) ? '0 : idx_inc[IW-1:0];

  // ---------------------------------------------------------------------------
  // Decrement pacing
  // ---------------------------------------------------------------------------
  logic tick;

`ifdef COUNTER_SCHED_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;

  // Held at zero outside RUN, so every RUN entry starts a fresh period.
  assign tick = (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q;
    if (state_q != S_RUN) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Never decrement a counter that already reads zero.
  assign cnt_dec = (state_q == S_RUN) & ~cnt_zero & tick;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    val_d    = val_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          idx_d   = pick_idx;
          val_d   = req_slice[pick_idx];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_SETTLE;
      end
      // One quiet cycle so cnt_zero reflects the freshly loaded value.
      S_SETTLE: begin
        state_d = cnt_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (cnt_zero) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rr_ptr_d = next_ptr;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with
  // the state they describe.
  always_comb begin
    grant_d     = '0;
    done_d      = '0;
    busy_d      = (state_d != S_IDLE);
    cnt_latch_d = (state_d == S_LOAD);
    cnt_in_d    = '0;
    if (state_d != S_IDLE) begin
      grant_d = {{(NREQ-1){1'b0}}, 1'b1} << idx_d;
    end
    if (state_d == S_DONE) begin
      done_d = {{(NREQ-1){1'b0}}, 1'b1} << idx_d;
    end
    if (state_d == S_LOAD) begin
      cnt_in_d = val_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      val_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      cnt_in_q    <= '0;
      cnt_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      val_q       <= val_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cnt_in_q    <= cnt_in_d;
      cnt_latch_q <= cnt_latch_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign cnt_in    = cnt_in_q;
  assign cnt_latch = cnt_latch_q;

  // ---------------------------------------------------------------------------
  // Structural properties
  // ---------------------------------------------------------------------------
  a_no_latch_and_dec : assert property (@(posedge clock) disable iff (!reset_n)
    !(cnt_latch && cnt_dec));

  a_grant_onehot : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(grant));

  a_done_in_grant : assert property (@(posedge clock) disable iff (!reset_n)
    ((done & ~grant) == '0));

endmodule

// File: tb/tb_counter_sched.sv
`timescale 1ns/1ps
module tb_counter_sched;

  localparam int NREQ     = 4;
  localparam int W        = 32;
  localparam int PRESCALE = 4;
`ifdef COUNTER_SCHED_PRESCALE_EN
  localparam int STEP = PRESCALE;
`else
  localparam int STEP = 1;
`endif

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req     = '0;
  logic [NREQ*W-1:0] req_val = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [W-1:0]      cnt_in;
  logic              cnt_latch;
  logic              cnt_dec;
  logic              cnt_zero;

  counter_sched #(.NREQ(NREQ), .W(W), .PRESCALE(PRESCALE)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .req_val  (req_val),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .cnt_in   (cnt_in),
    .cnt_latch(cnt_latch),
    .cnt_dec  (cnt_dec),
    .cnt_zero (cnt_zero)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural down-counter; deliberately not reset (contents go stale).
  logic [W-1:0] cnt_model = '0;
  always @(posedge clock) begin
    if (cnt_latch)    cnt_model <= cnt_in;
    else if (cnt_dec) cnt_model <= cnt_model - 1'b1;
  end
  assign cnt_zero = (cnt_model == '0);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int           idx;
    logic [W-1:0] val;
    int           load_cyc;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, got, want, cyc);
    end
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: compares DUT activity against the head of the expectation queue.
  int dec_seen  = 0;
  bit prev_done = 1'b0;
  always @(negedge clock) begin
    if (reset_n) begin
      chk("latch_with_dec", 64'(cnt_latch & cnt_dec), 64'd0);
      chk("dec_at_zero",    64'(cnt_dec & cnt_zero),  64'd0);
      if (prev_done) chk("busy_after_done", 64'(busy), 64'd0);
      if (cnt_latch) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_latch cnt_in=%0h at cycle %0d", cnt_in, cyc);
        end else begin
          chk("latch_value",   64'(cnt_in), 64'(exp_q[0].val));
          chk("latch_cycle",   64'(cyc),    64'(exp_q[0].load_cyc));
          chk("grant_at_load", 64'(grant),  64'(onehot(exp_q[0].idx)));
          chk("busy_at_load",  64'(busy),   64'd1);
        end
        dec_seen = 0;
      end
      if (cnt_dec) dec_seen++;
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done done=%b at cycle %0d", done, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_vector", 64'(done),     64'(onehot(e.idx)));
          chk("done_cycle",  64'(cyc),      64'(e.done_cyc));
          chk("dec_count",   64'(dec_seen), 64'(e.val));
          $display("txn req=%0d val=%0d load=%0d done=%0d decs=%0d",
                   e.idx, e.val, e.load_cyc, cyc, dec_seen);
        end
      end
      prev_done = (done != '0);
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scenario description and reference model
  // ---------------------------------------------------------------------------
  bit           sc_use  [NREQ];
  int           sc_arr  [NREQ];
  logic [W-1:0] sc_val  [NREQ];
  bit           sc_drop [NREQ];

  function automatic int svc_len(input logic [W-1:0] v);
    return (v == '0) ? 2 : int'(v) * STEP + 3;
  endfunction

  // Predicts the whole service schedule from arrivals and round-robin order,
  // returning the last done cycle.
  function automatic int plan(input int t0);
    bit   rem [NREQ];
    int   n_left = 0;
    int   t = t0;
    int   last = t0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = sc_use[i];
      if (sc_use[i]) n_left++;
    end
    while (n_left > 0) begin
      int pick = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j = (model_ptr + k) % NREQ;
        if (pick < 0 && rem[j] && (t0 + sc_arr[j] <= t)) pick = j;
      end
      if (pick < 0) begin
        int nxt = 1 << 30;
        for (int i = 0; i < NREQ; i++)
          if (rem[i] && t0 + sc_arr[i] < nxt) nxt = t0 + sc_arr[i];
        t = nxt;
      end else begin
        exp_t e;
        e.idx      = pick;
        e.val      = sc_val[pick];
        e.load_cyc = t + 1;
        e.done_cyc = t + 1 + svc_len(sc_val[pick]);
        exp_q.push_back(e);
        model_ptr  = (pick + 1) % NREQ;
        rem[pick]  = 1'b0;
        n_left--;
        last       = e.done_cyc;
        t          = e.done_cyc + 1;
      end
    end
    return last;
  endfunction

  task automatic hard_reset();
    reset_n = 1'b0;
    req     = '0;
    repeat (2) @(negedge clock);
    exp_q.delete();
    model_ptr = 0;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  // Called at a negedge with the DUT idle in the current cycle.
  task automatic run_scenario();
    int t0 = cyc;
    int n = 0;
    int served = 0;
    int limit;
    for (int i = 0; i < NREQ; i++) if (sc_use[i]) n++;
    limit = plan(t0) + 20;
    while (served < n && cyc <= limit) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!sc_use[i]) continue;
        if (cyc == t0 + sc_arr[i]) begin
          req[i] = 1'b1;
          req_val[i*W +: W] = sc_val[i];
        end
        if (grant[i]) begin
          // The captured value must be used, whatever the input does now.
          req_val[i*W +: W] = $urandom;
          if (sc_drop[i]) req[i] = 1'b0;
        end
        if (done[i]) begin
          served++;
          req[i] = 1'b0;
        end
      end
      @(negedge clock);
    end
    if (served < n) begin
      checks++; errors++;
      $display("FAIL scenario_timeout served=%0d expected=%0d at cycle %0d", served, n, cyc);
      hard_reset();
    end
    @(negedge clock);
  endtask

  task automatic clear_sc();
    for (int i = 0; i < NREQ; i++) begin
      sc_use[i] = 1'b0; sc_arr[i] = 0; sc_val[i] = '0; sc_drop[i] = 1'b0;
    end
  endtask

  task automatic single(input int idx, input logic [W-1:0] v);
    clear_sc();
    sc_use[idx] = 1'b1;
    sc_val[idx] = v;
    run_scenario();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    exp_t e;

    // Reset held with all requests active and equal values.
    clear_sc();
    for (int i = 0; i < NREQ; i++) begin
      sc_use[i] = 1'b1;
      sc_val[i] = 3;
      req[i]    = 1'b1;
      req_val[i*W +: W] = 3;
    end
    repeat (3) @(negedge clock);
    chk("reset_grant", 64'(grant),     64'd0);
    chk("reset_done",  64'(done),      64'd0);
    chk("reset_busy",  64'(busy),      64'd0);
    chk("reset_latch", 64'(cnt_latch), 64'd0);
    chk("reset_dec",   64'(cnt_dec),   64'd0);
    chk("reset_cin",   64'(cnt_in),    64'd0);
    reset_n = 1'b1;
    run_scenario();            // grants 0,1,2,3
    single(0, 3);              // round-robin wraps back to 0

    single(2, 5);
    single(1, 0);
    single(3, 3);

    // Reset in the middle of a long countdown.
    t0 = cyc;
    e.idx = 0; e.val = 32'h5555_5555; e.load_cyc = t0 + 1; e.done_cyc = -1;
    exp_q.push_back(e);
    req[0] = 1'b1;
    req_val[0 +: W] = 32'h5555_5555;
    while (cyc < t0 + 13) @(negedge clock);
    chk("midrun_busy",  64'(busy),  64'd1);
    chk("midrun_grant", 64'(grant), 64'b0001);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_grant", 64'(grant),     64'd0);
    chk("abort_done",  64'(done),      64'd0);
    chk("abort_busy",  64'(busy),      64'd0);
    chk("abort_latch", 64'(cnt_latch), 64'd0);
    chk("abort_dec",   64'(cnt_dec),   64'd0);
    req = '0;
    exp_q.delete();
    model_ptr = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    single(0, 2);

    // Randomised mixes of arrivals, values and early request drops.
    for (int s = 0; s < 25; s++) begin
      clear_sc();
      while (!(sc_use[0] | sc_use[1] | sc_use[2] | sc_use[3])) begin
        for (int i = 0; i < NREQ; i++) sc_use[i] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < NREQ; i++) begin
        sc_arr[i]  = $urandom_range(0, 12);
        sc_val[i]  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 6));
        sc_drop[i] = 1'($urandom_range(0, 1));
      end
      run_scenario();
    end

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL leftover_expectations remaining=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
